epw22_alu_responder: RTL and testbench
======================================

Name: epw22_alu_responder

Overview:
- Responder end of the EPW22 stimulus/response protocol.
- Accepts an opcode, tag and two operands from the stimulus driver's outputs (data, tag, op) and executes one ALU operation. The tag selects an added result delay.
- Returns result, rtag, valid and error, and drives ready to pace the driver.
- Synthesizable design-side counterpart that the testbench checks against the reference model.

Parameters:
- DATA_WIDTH, 8, operand width (matches def::data_width).
- RESULT_WIDTH, 16, result width (matches def::result_width); must be >= 2*DATA_WIDTH.
- TAG_WIDTH, 2, tag width (matches def::tag_width).
- OP_WIDTH, 3, opcode width (matches def::op_width).

Ports:
- clk  input  1  single system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- op  input  OP_WIDTH  opcode; sampled only on the start cycle.
- tag  input  TAG_WIDTH  delay index; sampled on the start cycle.
- data  input  DATA_WIDTH  operand A on the start cycle, operand B on the next cycle.
- ready  output  1  block can accept a new start.
- valid  output  1  one-cycle pulse: result, rtag and error are valid.
- result  output  RESULT_WIDTH  operation result.
- rtag  output  2  tag[1:0] of the completing operation.
- error  output  1  operation error; qualified by valid.

Behaviour:
- Reset (reset=0, async): state=IDLE, ready=1, valid=0, result=0, rtag=0, error=0, all operand/op/tag/count registers 0.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded and produces no valid.
- Opcodes:
  - 0 NOP: never starts.
  - 1 ADD, 2 SUB, 3 MUL, 4 AND, 5 OR, 6 XOR, 7 DIV.
- Arithmetic, with operands zero-extended to RESULT_WIDTH:
  - ADD: A+B (carry kept in bit DATA_WIDTH).
  - SUB: (A-B) mod 2^RESULT_WIDTH.
  - MUL: full unsigned product.
  - AND/OR/XOR: bitwise, zero-extended.
  - DIV: unsigned floor(A/B). If B==0: result=0, error=1.
  - error=0 for every other case.
- FSM states: IDLE, OPB, WAIT, DONE. Edge k is the start edge.
  - IDLE (ready=1): at edge k, if op!=0, capture op, tag and A=data; go to OPB; ready=0. If op==0, stay in IDLE.
  - OPB: at edge k+1, capture B=data and cnt=tag; go to WAIT.
  - WAIT: at each edge, if cnt==0, register result/error/rtag, set valid=1 and go to DONE; else cnt=cnt-1.
  - DONE: at the next edge, valid=0, ready=1, go to IDLE.
- Latency:
  - valid is high for exactly one cycle, following edge k+2+tag.
  - ready rises on edge k+3+tag, the same edge valid falls.
  - Minimum op-to-op spacing is 4+tag cycles.
- Inputs are ignored while ready=0: op/tag/data changes in OPB, WAIT or DONE do not affect the in-flight operation or start a new one.
- Start is never accepted in the same cycle valid is high.
- result and rtag hold their last values after valid drops. error returns to 0 with valid.
- tag wrap: maximum tag (3) gives 3 extra WAIT cycles. cnt never underflows.
- Reset released mid-cycle: the block resumes in IDLE with ready=1 after the first clk edge following deassertion.

Test Plan:
- Reset: hold reset=0 for 8 cycles with op=1 toggling -> ready=1, valid=0, result=0 throughout; no start occurs.
- ADD carry, tag=0: op=1, A=8'hFF at edge 0, then B=8'h01 -> valid pulse after edge 2 with result=16'h0100, rtag=0, error=0; ready=1 after edge 3.
- MUL with delay: op=3, tag=3, A=8'hFF, B=8'hFF -> valid only after edge 5, result=16'hFE01, rtag=3; ready low from edge 0 through edge 5.
- DIV by zero vs normal: op=7, A=8'd100, B=0 -> result=0, error=1. Then op=7, A=100, B=7 -> result=16'd14, error=0.
- SUB wrap, plus ignored inputs: op=2, A=8'h01, B=8'h02 -> result=16'hFFFF. During WAIT drive op=1, data=8'h55 -> no effect on result, no second valid.
- Reset mid-op: start op=1, tag=3; assert reset=0 asynchronously in WAIT -> valid never asserts, ready=1 immediately. After release, a new ADD 3+4 -> result=16'd7.

Source files
------------

// File: rtl/epw22_alu_responder.sv
// EPW22 responder: takes op/tag/operand A on a start cycle and operand B on the next cycle,
// then waits 'tag' extra cycles and presents a single-cycle valid with the ALU result.
module epw22_alu_responder #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int TAG_WIDTH    = 2,
  parameter int OP_WIDTH     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [TAG_WIDTH-1:0]    tag,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic                    ready,
  output logic                    valid,
  output logic [RESULT_WIDTH-1:0] result,
  output logic [1:0]              rtag,
  output logic                    error,
  output logic [1:0]              o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_OPB = 2'd1, S_WAIT = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_OR  = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(7);

  state_t                  r_state;
  state_t                  w_next;
  logic [OP_WIDTH-1:0]     r_op;
  logic [TAG_WIDTH-1:0]    r_tag;
  logic [TAG_WIDTH-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [RESULT_WIDTH-1:0] r_result;
  logic [1:0]              r_rtag;
  logic                    r_error;
  logic [RESULT_WIDTH-1:0] w_a_ext;
  logic [RESULT_WIDTH-1:0] w_b_ext;
  logic [RESULT_WIDTH-1:0] w_alu;
  logic                    w_err;

  assign w_a_ext = RESULT_WIDTH'(r_a);
  assign w_b_ext = RESULT_WIDTH'(r_b);

  always_comb begin
    w_alu = '0;
    w_err = 1'b0;
    case (r_op)
      OP_ADD: w_alu = w_a_ext + w_b_ext;
      OP_SUB: w_alu = w_a_ext - w_b_ext;
      OP_MUL: w_alu = w_a_ext * w_b_ext;
      OP_AND: w_alu = w_a_ext & w_b_ext;
      OP_OR:  w_alu = w_a_ext | w_b_ext;
      OP_XOR: w_alu = w_a_ext ^ w_b_ext;
      OP_DIV: begin
        if (r_b == '0) w_err = 1'b1;
        else           w_alu = w_a_ext / w_b_ext;
      end
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (op != '0) w_next = S_OPB;
      S_OPB:  w_next = S_WAIT;
      S_WAIT: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake: a start is taken only while ready=1 and op!=0; valid is a one-cycle
  // pulse in DONE, and ready cannot be high then, so a start never overlaps valid.
  always_comb begin
    ready = (r_state == S_IDLE);
    valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= '0;
      r_tag    <= '0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_rtag   <= '0;
      r_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (op != '0) begin
            r_op  <= op;
            r_tag <= tag;
            r_a   <= data;
          end
        end
        S_OPB: begin
          r_b   <= data;
          r_cnt <= r_tag;
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_result <= w_alu;
            r_error  <= w_err;
            r_rtag   <= r_tag[1:0];
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: r_error <= 1'b0;
        default: r_error <= 1'b0;
      endcase
    end
  end

  assign result      = r_result;
  assign rtag        = r_rtag;
  assign error       = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_epw22_alu_responder.sv
// Bench for epw22_alu_responder: directed vector table, reset corner cases and
// random operations checked against an arithmetic reference model.
module tb_epw22_alu_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  tag = '0;
  logic [7:0]  data = '0;
  logic        ready;
  logic        valid;
  logic [15:0] result;
  logic [1:0]  rtag;
  logic        error;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  tag;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  epw22_alu_responder #(
    .DATA_WIDTH(8), .RESULT_WIDTH(16), .TAG_WIDTH(2), .OP_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .tag(tag), .data(data),
    .ready(ready), .valid(valid), .result(result), .rtag(rtag),
    .error(error), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic on the opcode meaning.
  task automatic model(input int o, input int a, input int b, output logic [15:0] res, output logic err);
    int r;
    r = 0;
    err = 1'b0;
    case (o)
      1: r = a + b;
      2: r = (a - b + 65536) % 65536;
      3: r = a * b;
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: begin
        if (b == 0) err = 1'b1;
        else        r = a / b;
      end
      default: r = 0;
    endcase
    res = r[15:0];
  endtask

  // Drives one operation and watches 10 edges; junk is driven on op/tag/data
  // while the block is busy to confirm it is ignored.
  task automatic run_op(input logic [2:0] o, input logic [1:0] t, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_res, input logic exp_err,
                        input string name);
    int first_v, hits, first_r, ti;
    logic [15:0] got_res;
    logic        got_err;
    logic [1:0]  got_rtag;
    ti = int'(t);
    first_v = -1; hits = 0; first_r = -1;
    got_res = 'x; got_err = 1'bx; got_rtag = 'x;
    @(negedge clk);
    op = o; tag = t; data = a;
    @(posedge clk); #1;
    check({name, "_busy"}, 32'(ready), 32'd0);
    for (int e = 1; e <= 10; e++) begin
      @(negedge clk);
      data = (e == 1) ? b : 8'($urandom);
      if (e <= ti + 3) begin
        op  = 3'($urandom_range(0, 7));
        tag = 2'($urandom);
      end else begin
        op = '0;
      end
      @(posedge clk); #1;
      if (valid) begin
        hits++;
        if (first_v < 0) begin
          first_v = e; got_res = result; got_err = error; got_rtag = rtag;
        end
      end
      if (ready && first_r < 0) first_r = e;
    end
    check({name, "_latency"}, 32'(first_v), 32'(ti + 2));
    check({name, "_pulses"}, 32'(hits), 32'd1);
    check({name, "_ready_edge"}, 32'(first_r), 32'(ti + 3));
    check({name, "_result"}, 32'(got_res), 32'(exp_res));
    check({name, "_error"}, 32'(got_err), 32'(exp_err));
    check({name, "_rtag"}, 32'(got_rtag), 32'(t));
    check({name, "_hold"}, 32'(result), 32'(exp_res));
    check({name, "_err_clr"}, 32'(error), 32'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [1:0]  rt;
    logic [7:0]  ra, rb;
    logic [15:0] mres;
    logic        merr;

    vecs[0] = '{3'd1, 2'd0, 8'hFF, 8'h01, 16'h0100, 1'b0};
    vecs[1] = '{3'd3, 2'd3, 8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[2] = '{3'd7, 2'd1, 8'd100, 8'd0, 16'h0000, 1'b1};
    vecs[3] = '{3'd7, 2'd2, 8'd100, 8'd7, 16'd14, 1'b0};
    vecs[4] = '{3'd2, 2'd0, 8'h01, 8'h02, 16'hFFFF, 1'b0};
    vecs[5] = '{3'd4, 2'd1, 8'hF0, 8'h3C, 16'h0030, 1'b0};
    vecs[6] = '{3'd5, 2'd2, 8'hF0, 8'h0F, 16'h00FF, 1'b0};
    vecs[7] = '{3'd6, 2'd3, 8'hAA, 8'hFF, 16'h0055, 1'b0};
    vecs[8] = '{3'd1, 2'd2, 8'hFF, 8'hFF, 16'h01FE, 1'b0};

    // Reset held with op toggling: no start may occur.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      op = (i % 2 == 0) ? 3'd1 : 3'd0;
      data = 8'($urandom);
      @(posedge clk); #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
    end
    @(negedge clk);
    op = '0;
    reset = 1'b1;

    // NOP never starts.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data = 8'($urandom);
      @(posedge clk); #1;
      check("nop_ready", 32'(ready), 32'd1);
      check("nop_valid", 32'(valid), 32'd0);
    end

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err,
             $sformatf("vec%0d", i));

    // Asynchronous reset in WAIT discards the operation.
    @(negedge clk);
    op = 3'd1; tag = 2'd3; data = 8'd9;
    @(posedge clk);
    @(negedge clk);
    op = '0; data = 8'd9;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_ready", 32'(ready), 32'd1);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_hold_valid", 32'(valid), 32'd0);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_release_ready", 32'(ready), 32'd1);
    check("midrst_release_valid", 32'(valid), 32'd0);
    run_op(3'd1, 2'd0, 8'd3, 8'd4, 16'd7, 1'b0, "post_rst_add");

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(1, 7));
      rt = 2'($urandom);
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      model(int'(ro), int'(ra), int'(rb), mres, merr);
      run_op(ro, rt, ra, rb, mres, merr, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
